// File: rtl/motor_guard.sv
// motor_guard: safety stage between the PID loop and the four PWM generators.
//
// Purpose
//   Owns the motor arming sequence, clamps and rate-limits the PID duty
//   requests while armed, and drops every motor to zero on disarm or when the
//   PID stage stops sending updates (watchdog failsafe).
//
// Optional feature
//   MOTOR_GUARD_SLEW_EN  defined   : each update moves a channel by at most
//                                    SLEW_STEP from its previous output.
//                        undefined : the clamped target is loaded directly
//                                    (same one-cycle latency, SLEW_STEP unused).
//
// Ports
//   clk                    in   50 MHz clock, single domain
//   rst_n                  in   asynchronous active-low reset
//   duty_in_1..duty_in_4   in   [15:0] requested duties from the PID stage
//   duty_valid             in   one-cycle strobe qualifying duty_in_1..4
//   arm_req, disarm_req    in   level-sampled commands; disarm_req has priority
//   duty_out_1..duty_out_4 out  [15:0] duties to the PWM generators
//   duty_oe                out  one-cycle load strobe for duty_out_1..4
//   armed                  out  high only in ARMED
//   failsafe               out  high only in FAILSAFE
//   fsm_state              out  [1:0] debug view of the state register
//                               (0 DISARMED, 1 ARMING, 2 ARMED, 3 FAILSAFE)
//
// Handshake: duty_valid is a strobe with no back-pressure. Every strobe seen
// in ARMED (and not overridden by disarm_req) yields exactly one duty_oe pulse
// on the following cycle, with the new duties already on duty_out_1..4.
module motor_guard #(
    parameter logic [15:0] DUTY_IDLE  = 16'd3000,
    parameter logic [15:0] DUTY_MAX   = 16'd60000,
    parameter logic [15:0] SLEW_STEP  = 16'd2000,
    parameter logic [15:0] ARM_STEP   = 16'd100,
    parameter logic [31:0] ARM_TICK   = 32'd50000,
    parameter logic [31:0] WD_TIMEOUT = 32'd2500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] duty_in_1,
    input  logic [15:0] duty_in_2,
    input  logic [15:0] duty_in_3,
    input  logic [15:0] duty_in_4,
    input  logic        duty_valid,
    input  logic        arm_req,
    input  logic        disarm_req,
    output logic [15:0] duty_out_1,
    output logic [15:0] duty_out_2,
    output logic [15:0] duty_out_3,
    output logic [15:0] duty_out_4,
    output logic        duty_oe,
    output logic        armed,
    output logic        failsafe,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2,
        FAILSAFE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] duty_q [4];
    logic [15:0] duty_d [4];
    logic [15:0] din    [4];
    logic        oe_q, oe_d;
    logic [31:0] tick_q, tick_d;
    logic [31:0] wd_q, wd_d;
    logic        all_idle;

    assign din[0] = duty_in_1;
    assign din[1] = duty_in_2;
    assign din[2] = duty_in_3;
    assign din[3] = duty_in_4;

    // Clamp into the armed operating window; 16-bit inputs cannot wrap here.
    function automatic logic [15:0] clamp_duty(input logic [15:0] req);
        logic [15:0] t;
        t = req;
        if (t < DUTY_IDLE) t = DUTY_IDLE;
        if (t > DUTY_MAX)  t = DUTY_MAX;
        return t;
    endfunction

`ifdef MOTOR_GUARD_SLEW_EN
    // Rate limit in 17 bits so prev + SLEW_STEP never wraps; the lower bound
    // is only taken when prev > tgt + SLEW_STEP, so prev - SLEW_STEP cannot
    // underflow.
    function automatic logic [15:0] slew_duty(input logic [15:0] tgt,
                                              input logic [15:0] prev);
        logic [16:0] t17, p17, s17, hi, res;
        t17 = {1'b0, tgt};
        p17 = {1'b0, prev};
        s17 = {1'b0, SLEW_STEP};
        hi  = p17 + s17;
        res = t17;
        if (t17 > hi)              res = hi;
        else if (t17 + s17 < p17)  res = p17 - s17;
        return res[15:0];
    endfunction
`else
    logic unused_slew;
    assign unused_slew = ^SLEW_STEP;
`endif

    // One arming increment, saturating at the idle duty.
    function automatic logic [15:0] arm_inc(input logic [15:0] prev);
        logic [16:0] sum;
        sum = {1'b0, prev} + {1'b0, ARM_STEP};
        if (sum >= {1'b0, DUTY_IDLE}) return DUTY_IDLE;
        return sum[15:0];
    endfunction

    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (duty_q[i] != DUTY_IDLE) all_idle = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        wd_d    = wd_q;
        oe_d    = 1'b0;
        for (int i = 0; i < 4; i++) duty_d[i] = duty_q[i];

        if (disarm_req) begin
            // Highest priority: beats arm_req, duty_valid and watchdog expiry.
            state_d = DISARMED;
            tick_d  = '0;
            wd_d    = '0;
            for (int i = 0; i < 4; i++) duty_d[i] = '0;
            // DISARMED outputs are already 0, so no reload strobe there.
            oe_d    = (state_q != DISARMED);
        end else begin
            unique case (state_q)
                DISARMED: begin
                    if (arm_req) begin
                        state_d = ARMING;
                        tick_d  = '0;
                    end
                end
                ARMING: begin
                    if (all_idle) begin
                        state_d = ARMED;
                        tick_d  = '0;
                        wd_d    = '0;
                    end else if (tick_q == ARM_TICK - 32'd1) begin
                        tick_d = '0;
                        oe_d   = 1'b1;
                        for (int i = 0; i < 4; i++) duty_d[i] = arm_inc(duty_q[i]);
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                end
                ARMED: begin
                    if (duty_valid) begin
                        wd_d = '0;
                        oe_d = 1'b1;
                        for (int i = 0; i < 4; i++) begin
`ifdef MOTOR_GUARD_SLEW_EN
                            duty_d[i] = slew_duty(clamp_duty(din[i]), duty_q[i]);
`else
                            duty_d[i] = clamp_duty(din[i]);
`endif
                        end
                    end else if (wd_q == WD_TIMEOUT - 32'd1) begin
                        state_d = FAILSAFE;
                        wd_d    = '0;
                        oe_d    = 1'b1;
                        for (int i = 0; i < 4; i++) duty_d[i] = '0;
                    end else begin
                        wd_d = wd_q + 32'd1;
                    end
                end
                FAILSAFE: begin
                    // Latched until disarm_req; everything else ignored.
                end
                default: begin
                    state_d = DISARMED;
                    for (int i = 0; i < 4; i++) duty_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DISARMED;
            oe_q    <= 1'b0;
            tick_q  <= '0;
            wd_q    <= '0;
            for (int i = 0; i < 4; i++) duty_q[i] <= '0;
        end else begin
            state_q <= state_d;
            oe_q    <= oe_d;
            tick_q  <= tick_d;
            wd_q    <= wd_d;
            for (int i = 0; i < 4; i++) duty_q[i] <= duty_d[i];
        end
    end

    assign duty_out_1 = duty_q[0];
    assign duty_out_2 = duty_q[1];
    assign duty_out_3 = duty_q[2];
    assign duty_out_4 = duty_q[3];
    assign duty_oe    = oe_q;
    assign armed      = (state_q == ARMED);
    assign failsafe   = (state_q == FAILSAFE);
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_motor_guard.sv
// Self-checking bench for motor_guard (ARM_TICK=4, WD_TIMEOUT=100).
// Expected duty words (four channels packed, channel 1 in the top bits) are
// queued as stimulus is driven; a negedge monitor pops one per duty_oe pulse.
module tb_motor_guard;

    localparam int IDLE     = 3000;
    localparam int DMAX     = 60000;
    localparam int SLEW     = 2000;
    localparam int ASTEP    = 100;
    localparam int ATICK    = 4;
    localparam int WDT      = 100;

    logic        clk;
    logic        rst_n;
    logic [15:0] duty_in_1, duty_in_2, duty_in_3, duty_in_4;
    logic        duty_valid, arm_req, disarm_req;
    logic [15:0] duty_out_1, duty_out_2, duty_out_3, duty_out_4;
    logic        duty_oe, armed, failsafe;
    logic [1:0]  fsm_state;

    motor_guard #(
        .DUTY_IDLE (16'd3000),
        .DUTY_MAX  (16'd60000),
        .SLEW_STEP (16'd2000),
        .ARM_STEP  (16'd100),
        .ARM_TICK  (32'd4),
        .WD_TIMEOUT(32'd100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .duty_in_1 (duty_in_1),
        .duty_in_2 (duty_in_2),
        .duty_in_3 (duty_in_3),
        .duty_in_4 (duty_in_4),
        .duty_valid(duty_valid),
        .arm_req   (arm_req),
        .disarm_req(disarm_req),
        .duty_out_1(duty_out_1),
        .duty_out_2(duty_out_2),
        .duty_out_3(duty_out_3),
        .duty_out_4(duty_out_4),
        .duty_oe   (duty_oe),
        .armed     (armed),
        .failsafe  (failsafe),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [15:0] mdl [4];
    logic        gap_chk = 1'b0;
    logic        have_last = 1'b0;
    int          last_oe = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {duty_out_1, duty_out_2, duty_out_3, duty_out_4};
    endfunction

    always @(negedge clk) begin
        if (rst_n && duty_oe) begin
            if (exp_q.size() == 0) check("spurious_oe", 64'd1, 64'd0);
            else                   check("duty", outs(), exp_q.pop_front());
            if (gap_chk) begin
                if (have_last) check("arm_gap", 64'(cyc - last_oe), 64'(ATICK));
                have_last = 1'b1;
                last_oe   = cyc;
            end
        end
    end

    // ---------------- reference model ----------------
`ifdef MOTOR_GUARD_SLEW_EN
    function automatic logic [15:0] model_duty(input logic [15:0] req, input logic [15:0] prev);
        int t, p;
        t = int'(req);
        p = int'(prev);
        if (t < IDLE) t = IDLE;
        if (t > DMAX) t = DMAX;
        if (t - p > SLEW)      t = p + SLEW;
        else if (p - t > SLEW) t = p - SLEW;
        return t[15:0];
    endfunction
`else
    function automatic logic [15:0] model_duty(input logic [15:0] req, input logic [15:0] prev);
        int t;
        t = int'(req) + 0 * int'(prev);
        if (t < IDLE) t = IDLE;
        if (t > DMAX) t = DMAX;
        return t[15:0];
    endfunction
`endif

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one duty request this cycle and queues its expected result.
    task automatic put_duty(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r [4];
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        for (int i = 0; i < 4; i++) mdl[i] = model_duty(r[i], mdl[i]);
        exp_q.push_back({mdl[0], mdl[1], mdl[2], mdl[3]});
        duty_in_1 = a; duty_in_2 = b; duty_in_3 = c; duty_in_4 = d;
        duty_valid = 1'b1;
    endtask

    task automatic do_arm(input logic track_gap);
        logic [15:0] v;
        for (int k = 1; k <= IDLE / ASTEP; k++) begin
            v = 16'(k * ASTEP);
            exp_q.push_back({v, v, v, v});
        end
        have_last = 1'b0;
        gap_chk   = track_gap;
        arm_req   = 1'b1;
        step();
        arm_req   = 1'b0;
    endtask

    task automatic wait_armed();
        int n;
        n = 0;
        while (!armed && n < 300) begin
            step();
            n++;
        end
        check("armed_reached", 64'(armed), 64'd1);
        gap_chk = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 16'(IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        duty_in_1 = '0; duty_in_2 = '0; duty_in_3 = '0; duty_in_4 = '0;
        duty_valid = 1'b0; arm_req = 1'b0; disarm_req = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs",     outs(),           64'd0);
        check("rst_oe",       64'(duty_oe),     64'd0);
        check("rst_armed",    64'(armed),       64'd0);
        check("rst_failsafe", 64'(failsafe),    64'd0);
        check("rst_state",    64'(fsm_state),   64'd0);
        rst_n = 1'b1;
        step();

        // duty_valid while disarmed does nothing
        duty_valid = 1'b1; duty_in_1 = 16'd9000;
        step();
        duty_valid = 1'b0;
        step();
        check("disarmed_hold", outs(), 64'd0);

        // Arming ramp 100..3000, one oe every 4 cycles
        do_arm(1'b1);
        wait_armed();
        check("armed_outs", outs(), {4{16'd3000}});

        // Reference vector, latency exactly one cycle
        put_duty(16'd10000, 16'd0, 16'd65535, 16'd4000);
        step();
        duty_valid = 1'b0;
        check("lat_ref", 64'(duty_oe), 64'd1);
`ifdef MOTOR_GUARD_SLEW_EN
        check("ref_vec", outs(), {16'd5000, 16'd3000, 16'd5000, 16'd4000});
`else
        check("ref_vec", outs(), {16'd10000, 16'd3000, 16'd60000, 16'd4000});
`endif
        step();
        check("oe_one_cycle", 64'(duty_oe), 64'd0);

        // Back-to-back random strobes
        for (int k = 0; k < 8; k++) begin
            put_duty(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                     16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            step();
            check("lat_b2b", 64'(duty_oe), 64'd1);
        end
        duty_valid = 1'b0;
        step();
        check("b2b_end", 64'(duty_oe), 64'd0);

        // Spaced updates including the clamp boundaries
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 20)) step();
            if (k == 0) put_duty(16'd0, 16'd65535, 16'd3000, 16'd60000);
            else put_duty(16'($urandom_range(0, 65535)), 16'($urandom_range(2500, 3500)),
                          16'($urandom_range(59000, 65535)), 16'($urandom_range(0, 65535)));
            step();
            duty_valid = 1'b0;
        end

        // Watchdog expiry -> FAILSAFE with one zeroing oe
        exp_q.push_back(64'd0);
        repeat (50) step();
        check("wd_early", 64'(failsafe), 64'd0);
        n = 0;
        while (!failsafe && n < 2 * WDT) begin
            step();
            n++;
        end
        check("wd_failsafe", 64'(failsafe), 64'd1);
        check("wd_armed",    64'(armed),    64'd0);
        check("wd_outs",     outs(),        64'd0);

        // arm_req and duty_valid ignored in FAILSAFE
        arm_req = 1'b1;
        step();
        arm_req = 1'b0;
        duty_valid = 1'b1; duty_in_1 = 16'd20000;
        step();
        duty_valid = 1'b0;
        repeat (8) step();
        check("fs_latched", 64'(failsafe), 64'd1);
        check("fs_outs",    outs(),        64'd0);

        // disarm_req leaves FAILSAFE (one oe pulse, outputs 0)
        exp_q.push_back(64'd0);
        disarm_req = 1'b1;
        step();
        disarm_req = 1'b0;
        check("fs_exit_state", 64'(fsm_state), 64'd0);
        check("fs_exit_flag",  64'(failsafe),  64'd0);
        step();

        // Re-arm, then duty_valid and disarm_req together
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        do_arm(1'b0);
        wait_armed();
        exp_q.push_back(64'd0);
        duty_in_1 = 16'd9000; duty_in_2 = 16'd9000; duty_in_3 = 16'd9000; duty_in_4 = 16'd9000;
        duty_valid = 1'b1;
        disarm_req = 1'b1;
        step();
        duty_valid = 1'b0;
        disarm_req = 1'b0;
        check("dis_win_outs",  outs(),      64'd0);
        check("dis_win_armed", 64'(armed),  64'd0);
        check("dis_win_oe",    64'(duty_oe), 64'd1);

        // disarm while already disarmed: no oe (monitor catches a stray one)
        step();
        disarm_req = 1'b1;
        step();
        disarm_req = 1'b0;
        check("dis_idle_oe", 64'(duty_oe), 64'd0);

        // Reset in the middle of arming at 1500
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        do_arm(1'b0);
        n = 0;
        while (duty_out_1 != 16'd1500 && n < 200) begin
            step();
            n++;
        end
        check("mid_arm_level", 64'(duty_out_1), 64'd1500);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_outs",  outs(),           64'd0);
        check("async_rst_state", 64'(fsm_state),   64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("post_rst_oe", 64'(duty_oe), 64'd0);
        repeat (12) step();
        check("post_rst_outs",  outs(),         64'd0);
        check("post_rst_armed", 64'(armed),     64'd0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_guard.md
MOTOR_GUARD -- requirements
Module: motor_guard

Interface
REQ-001 SHALL have parameter DUTY_IDLE, 16'd3000, armed minimum duty (idle spin).
REQ-002 SHALL have parameter DUTY_MAX, 16'd60000, maximum duty.
REQ-003 SHALL have parameter SLEW_STEP, 16'd2000, maximum per-update duty change per channel.
REQ-004 SHALL have parameter ARM_STEP, 16'd100, duty increment per arming tick.
REQ-005 SHALL have parameter ARM_TICK, 32'd50000, cycles between arming increments (1 ms at 50 MHz).
REQ-006 SHALL have parameter WD_TIMEOUT, 32'd2500000, cycles without duty_valid before failsafe (50 ms).
REQ-007 SHALL have port clk, input, 1, 50 MHz clock; one clock domain.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports duty_in_1..duty_in_4, input, 16 each, requested motor duties from the PID stage.
REQ-010 SHALL have port duty_valid, input, 1, one-cycle strobe qualifying duty_in_1..4.
REQ-011 SHALL have ports arm_req and disarm_req, input, 1 each, level-sampled commands.
REQ-012 SHALL have ports duty_out_1..duty_out_4, output, 16 each, duties to the PWM generators.
REQ-013 SHALL have port duty_oe, output, 1, one-cycle load strobe for duty_out_1..4.
REQ-014 SHALL have ports armed and failsafe, output, 1 each, status flags.

Function
REQ-015 SHALL implement states DISARMED, ARMING, ARMED, FAILSAFE.
REQ-016 DISARMED: outputs 0; arm_req=1 with disarm_req=0 -> ARMING, tick counter cleared, duty_out 0.
REQ-017 ARMING: every ARM_TICK cycles, all duty_out += ARM_STEP (saturating at DUTY_IDLE) with a duty_oe pulse; the cycle all outputs equal DUTY_IDLE -> ARMED; duty_valid ignored.
REQ-018 ARMED: on duty_valid, each channel target = clamp(duty_in, DUTY_IDLE, DUTY_MAX); new output = target limited to prev +/- SLEW_STEP; computed in 17 bits without wrap; results registered and duty_oe pulsed exactly one cycle after the duty_valid cycle.
REQ-019 Back-to-back duty_valid strobes SHALL each produce one update and one duty_oe pulse, latency 1.
REQ-020 Watchdog counter SHALL run only in ARMED, clear on every duty_valid; reaching WD_TIMEOUT -> FAILSAFE.
REQ-021 FAILSAFE entry SHALL set all duty_out to 0 with one duty_oe pulse, failsafe=1; duty_valid and arm_req ignored; only disarm_req exits, to DISARMED.
REQ-022 disarm_req=1 in any state SHALL go to DISARMED next cycle, outputs 0, one duty_oe pulse (none if outputs already 0 in DISARMED); disarm_req beats arm_req, duty_valid and watchdog expiry in the same cycle.
REQ-023 armed=1 only in ARMED; failsafe=1 only in FAILSAFE.

Reset
REQ-024 rst_n low SHALL asynchronously force DISARMED, duty_out_1..4=0, duty_oe=0, armed=0, failsafe=0, all counters 0.
REQ-025 Reset mid-ARMING or mid-update SHALL discard pending work; no duty_oe in the first cycle after release.

Configuration
REQ-026 Macro MOTOR_GUARD_SLEW_EN defined: slew limiting per REQ-018 applied.
REQ-027 MOTOR_GUARD_SLEW_EN undefined: clamped target loaded directly, same latency; SLEW_STEP unused.

Verification (ARM_TICK=4, WD_TIMEOUT=100, other defaults)
REQ-028 arm_req pulse -> duty_oe every 4 cycles, outputs 100,200,...,3000 in 30 steps, then armed=1.
REQ-029 ARMED at 3000, duty_valid with duty_in_1=10000, duty_in_2=0, duty_in_3=65535, duty_in_4=4000 -> next cycle outputs 5000,3000,5000,4000 (slew on); 10000,3000,60000,4000 with macro undefined.
REQ-030 ARMED, no duty_valid for 100 cycles -> FAILSAFE, outputs 0, one duty_oe, failsafe=1; later arm_req ignored; disarm_req -> DISARMED.
REQ-031 ARMED, duty_valid and disarm_req same cycle -> DISARMED, outputs 0, no duty update applied.
REQ-032 rst_n asserted during ARMING at output 1500 -> all outputs 0 immediately, state DISARMED, no duty_oe after release.
